// File: rtl/seq_gen_pkg.sv
// Shared constants for the fixed-pattern nibble sequence generator.
// The pattern table lives here so the ROM and any reference logic agree.
package seq_gen_pkg;

  localparam int SEQ_LEN = 8;
  localparam int DATA_W  = 4;
  localparam int IDX_W   = 3;

  localparam logic [DATA_W-1:0] PATTERN [SEQ_LEN] = '{
    4'hA, 4'hB, 4'hE, 4'h7, 4'hF, 4'h2, 4'h0, 4'hD
  };

endpackage

// File: rtl/seq_gen_rom.sv
// Combinational lookup of the constant pattern by position.
module seq_gen_rom
  import seq_gen_pkg::*;
(
  input  logic [IDX_W-1:0]  addr_i,
  output logic [DATA_W-1:0] value_o
);

  assign value_o = PATTERN[addr_i];

endmodule

// File: rtl/seq_generator.sv
// Emits one pattern nibble per enabled clock, wrapping after the last entry.
// Optional SEQ_GEN_STATUS_EN exposes the next-entry pointer on the index port.
module seq_generator
  import seq_gen_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              wrap
`ifdef SEQ_GEN_STATUS_EN
  ,
  output logic [IDX_W-1:0]  index
`endif
);

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rom_value;

  seq_gen_rom u_rom (
    .addr_i  (ptr_q),
    .value_o (rom_value)
  );

  always_comb begin
    ptr_d   = ptr_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (enable) begin
      ptr_d   = ptr_q + IDX_W'(1);
      data_d  = rom_value;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Pointer back at 0 with valid set means the last entry is on data.
  assign wrap  = valid_q && (ptr_q == '0);
  assign data  = data_q;
  assign valid = valid_q;

`ifdef SEQ_GEN_STATUS_EN
  assign index = ptr_q;
`endif

endmodule

// File: tb/tb_seq_generator.sv
// Self-checking bench for seq_generator: vector table plus hand-written corner sequences.
module tb_seq_generator;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] data;
  logic       valid;
  logic       wrap;
`ifdef SEQ_GEN_STATUS_EN
  logic [2:0] index;
`endif

  seq_generator dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .data   (data),
    .valid  (valid),
    .wrap   (wrap)
`ifdef SEQ_GEN_STATUS_EN
    ,
    .index  (index)
`endif
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] d;
    logic       v;
    logic       w;
    logic [2:0] idx;
  } vec_t;

  vec_t       vecs [17];
  vec_t       sb_q [$];
  logic [3:0] pat  [8];
  int         errors = 0;
  int         checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    vec_t e;
    if (sb_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb_q.pop_front();
    check({tag, ".data"},  {4'h0, data},  {4'h0, e.d});
    check({tag, ".valid"}, {7'h0, valid}, {7'h0, e.v});
    check({tag, ".wrap"},  {7'h0, wrap},  {7'h0, e.w});
`ifdef SEQ_GEN_STATUS_EN
    check({tag, ".index"}, {5'h0, index}, {5'h0, e.idx});
`endif
  endtask

  // Drive at negedge, let one rising edge pass, compare at the following negedge.
  task automatic apply(input logic r, input logic en, input logic [3:0] d,
                       input logic v, input logic w, input logic [2:0] idx,
                       input string tag);
    vec_t e;
    reset  = r;
    enable = en;
    e = '{rst: r, en: en, d: d, v: v, w: w, idx: idx};
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    pat[0] = 4'hA; pat[1] = 4'hB; pat[2] = 4'hE; pat[3] = 4'h7;
    pat[4] = 4'hF; pat[5] = 4'h2; pat[6] = 4'h0; pat[7] = 4'hD;

    //            rst   en    data  vld   wrap  idx
    vecs[0]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0};
    vecs[1]  = '{1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 3'd1};
    vecs[2]  = '{1'b0, 1'b1, 4'hB, 1'b1, 1'b0, 3'd2};
    vecs[3]  = '{1'b0, 1'b1, 4'hE, 1'b1, 1'b0, 3'd3};
    vecs[4]  = '{1'b0, 1'b0, 4'hE, 1'b1, 1'b0, 3'd3};
    vecs[5]  = '{1'b0, 1'b0, 4'hE, 1'b1, 1'b0, 3'd3};
    vecs[6]  = '{1'b0, 1'b0, 4'hE, 1'b1, 1'b0, 3'd3};
    vecs[7]  = '{1'b0, 1'b1, 4'h7, 1'b1, 1'b0, 3'd4};
    vecs[8]  = '{1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 3'd5};
    vecs[9]  = '{1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 3'd6};
    vecs[10] = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 3'd7};
    vecs[11] = '{1'b0, 1'b1, 4'hD, 1'b1, 1'b1, 3'd0};
    vecs[12] = '{1'b0, 1'b0, 4'hD, 1'b1, 1'b1, 3'd0};
    vecs[13] = '{1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 3'd1};
    vecs[14] = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 3'd0};
    vecs[15] = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 3'd0};
    vecs[16] = '{1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 3'd1};

    reset  = 1'b1;
    enable = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      apply(vecs[i].rst, vecs[i].en, vecs[i].d, vecs[i].v, vecs[i].w,
            vecs[i].idx, $sformatf("vec%0d", i));
    end

    // Full run from reset: nine enabled edges, ninth wraps to 0xA.
    apply(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, "run_rst");
    for (int k = 0; k < 9; k++) begin
      apply(1'b0, 1'b1, pat[k % 8], 1'b1, ((k % 8) == 7), 3'((k + 1) % 8),
            $sformatf("run%0d", k));
    end

    // Enable pulse entirely between rising edges must not advance.
    enable = 1'b0;
    #2 enable = 1'b1;
    #1 enable = 1'b0;
    sb_q.push_back('{rst: 1'b0, en: 1'b0, d: 4'hA, v: 1'b1, w: 1'b0, idx: 3'd1});
    @(posedge clk);
    @(negedge clk);
    check_outputs("glitch");

    // Advance to 0xF, then reset asynchronously between edges.
    apply(1'b0, 1'b1, 4'hB, 1'b1, 1'b0, 3'd2, "pre_b");
    apply(1'b0, 1'b1, 4'hE, 1'b1, 1'b0, 3'd3, "pre_e");
    apply(1'b0, 1'b1, 4'h7, 1'b1, 1'b0, 3'd4, "pre_7");
    apply(1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 3'd5, "pre_f");
    enable = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async.data",  {4'h0, data},  8'h00);
    check("async.valid", {7'h0, valid}, 8'h00);
    check("async.wrap",  {7'h0, wrap},  8'h00);
`ifdef SEQ_GEN_STATUS_EN
    check("async.index", {5'h0, index}, 8'h00);
`endif
    @(negedge clk);
    apply(1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 3'd1, "post_rst");

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
    end
    checks++;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
